// File: rtl/md_step_seq.sv
// G-15 multiply/divide/shift step sequencer: word alignment, even/odd word strobes, step count.
// Optional feature: define G15_MD_NORMALIZE_EN to let NORM (MD_OP=3) stop early on ID_MSB.
module md_step_seq #(
    parameter int STEP_W = 7
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              T29,
    input  logic              MD_GO,
    input  logic [1:0]        MD_OP,
    input  logic [STEP_W-1:0] STEPS,
    input  logic              ID_MSB,
    output logic              DS,
    output logic              CE,
    output logic              TE,
    output logic              OP_MUL,
    output logic              OP_DIV,
    output logic              BUSY,
    output logic              DONE,
    output logic [STEP_W-1:0] CNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_RUN,
        S_FIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ce;
    logic              w_ce_nxt;
    logic [STEP_W-1:0] r_cnt;
    logic [STEP_W-1:0] w_cnt_nxt;
    logic [STEP_W-1:0] w_cnt_dec;
    logic [1:0]        r_op;
    logic [1:0]        w_op_nxt;
    logic              w_norm_stop;

`ifdef G15_MD_NORMALIZE_EN
    assign w_norm_stop = (r_op == 2'd3) && ID_MSB;
`else
    logic w_unused_id_msb;
    assign w_unused_id_msb = ID_MSB;
    assign w_norm_stop     = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ce    <= 1'b0;
            r_cnt   <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ce    <= w_ce_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ce_nxt    = r_ce;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_cnt_dec   = (r_cnt != '0) ? (r_cnt - STEP_W'(1)) : r_cnt;
        DS          = 1'b0;
        TE          = 1'b0;
        BUSY        = 1'b0;
        DONE        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ce_nxt = 1'b0;
                if (MD_GO) begin
                    w_op_nxt    = MD_OP;
                    w_cnt_nxt   = STEPS;
                    w_state_nxt = S_SYNC;
                end
            end
            S_SYNC: begin
                BUSY = 1'b1;
                if (T29) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_ce_nxt    = 1'b1;
                    end
                end
            end
            S_RUN: begin
                DS   = 1'b1;
                BUSY = 1'b1;
                if (T29) begin
                    if (r_ce) begin
                        w_ce_nxt = 1'b0;
                    end else begin
                        TE = 1'b1;
                        // Normalise stop leaves CNT at the number of steps not performed.
                        if (w_norm_stop) begin
                            w_state_nxt = S_FIN;
                            w_ce_nxt    = 1'b0;
                        end else begin
                            w_cnt_nxt = w_cnt_dec;
                            if (w_cnt_dec == '0) begin
                                w_state_nxt = S_FIN;
                                w_ce_nxt    = 1'b0;
                            end else begin
                                w_ce_nxt = 1'b1;
                            end
                        end
                    end
                end
            end
            S_FIN: begin
                DONE        = 1'b1;
                w_ce_nxt    = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_ce_nxt    = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign CE     = r_ce;
    assign CNT    = r_cnt;
    assign OP_MUL = DS && (r_op == 2'd0);
    assign OP_DIV = DS && (r_op == 2'd1);

endmodule

// File: tb/tb_md_step_seq.sv
// Self-checking bench for md_step_seq: table-driven runs scored at DONE, plus reset and MD_GO-ignore sequences.
module tb_md_step_seq;

    localparam int W = 7;

    logic         CLOCK = 1'b0;
    logic         rst;
    logic         T29;
    logic         MD_GO;
    logic [1:0]   MD_OP;
    logic [W-1:0] STEPS;
    logic         ID_MSB;
    logic         DS, CE, TE, OP_MUL, OP_DIV, BUSY, DONE;
    logic [W-1:0] CNT;

    md_step_seq #(.STEP_W(W)) dut (
        .CLOCK  (CLOCK),
        .rst    (rst),
        .T29    (T29),
        .MD_GO  (MD_GO),
        .MD_OP  (MD_OP),
        .STEPS  (STEPS),
        .ID_MSB (ID_MSB),
        .DS     (DS),
        .CE     (CE),
        .TE     (TE),
        .OP_MUL (OP_MUL),
        .OP_DIV (OP_DIV),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .CNT    (CNT)
    );

    always #5 CLOCK = ~CLOCK;

    // op, steps, MD_GO phase, stop at k-th odd T29 (0=never), DS rise delay, TE count, DS clocks, CE clocks, final CNT
    typedef struct {
        int op;
        int steps;
        int go_ph;
        int stop_k;
        int rise;
        int te;
        int ds;
        int ce;
        int cnt;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[8];
    vec_t cur;
    int   checks = 0;
    int   errors = 0;
    int   ph;
    int   te_cnt, ds_cnt, ce_cnt;
    logic prev_done;
    int   held_cnt;

    // Free-running word-time marker: T29 high one clock in every 29.
    initial begin
        ph  = 0;
        T29 = 1'b0;
        forever begin
            @(posedge CLOCK);
            #2;
            ph  = (ph == 28) ? 0 : ph + 1;
            T29 = (ph == 28);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clear_counts();
        te_cnt = 0;
        ds_cnt = 0;
        ce_cnt = 0;
    endtask

    task automatic observe();
        chk("te_strobe", int'(TE), int'(T29 && DS && !CE));
        if (!DS) begin
            chk("op_gated", int'({OP_MUL, OP_DIV}), 0);
        end else if (sb.size() > 0) begin
            chk("op_mul", int'(OP_MUL), int'(sb[0].op == 0));
            chk("op_div", int'(OP_DIV), int'(sb[0].op == 1));
        end
        if (DS) ds_cnt++;
        if (DS && CE) ce_cnt++;
        if (TE) te_cnt++;
        if (prev_done) begin
            chk("done_width", int'(DONE), 0);
            chk("cnt_held", int'(CNT), held_cnt);
        end
        if (DONE) begin
            chk("done_ds", int'(DS), 0);
            chk("done_ce", int'(CE), 0);
            chk("done_busy", int'(BUSY), 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got DONE=1 expected no completion (t=%0t)", $time);
            end else begin
                cur = sb.pop_front();
                chk("te_pulses", te_cnt, cur.te);
                chk("ds_clocks", ds_cnt, cur.ds);
                chk("ce_clocks", ce_cnt, cur.ce);
                chk("cnt_final", int'(CNT), cur.cnt);
            end
            clear_counts();
        end
        prev_done = DONE;
        held_cnt  = int'(CNT);
    endtask

    task automatic clk();
        @(posedge CLOCK);
        #3;
        observe();
    endtask

    task automatic wait_ph(input int p);
        int n;
        n = 0;
        do begin
            clk();
            n++;
        end while (ph != p && n < 40);
        if (ph != p) chk("phase_wait", ph, p);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            clk();
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no DONE expected one within %0d clocks", budget);
            sb.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        int rise;
        int n;
        wait_ph(v.go_ph);
        MD_OP = 2'(v.op);
        STEPS = W'(v.steps);
        MD_GO = 1'b1;
        sb.push_back(v);
        clk();
        MD_GO = 1'b0;
        chk("busy_after_go", int'(BUSY), 1);
        k    = 1;
        rise = -1;
        n    = 0;
        while (sb.size() > 0 && n < v.steps * 58 + 100) begin
            ID_MSB = (v.stop_k > 0) && (te_cnt >= v.stop_k);
            clk();
            k++;
            n++;
            if (DS && rise < 0) rise = k - 1;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no DONE expected one for op=%0d steps=%0d", v.op, v.steps);
            sb.delete();
        end
        ID_MSB = 1'b0;
        if (v.rise >= 0) chk("ds_rise_delay", rise, v.rise);
        clk();
    endtask

    initial begin
        int   n;
        logic busy_seen;

        vecs[0] = '{0, 3, 27, 0, 1, 3, 174, 87, 0};
        vecs[1] = '{2, 0, 10, 0, -1, 0, 0, 0, 0};
        vecs[2] = '{1, 1, 28, 0, 29, 1, 58, 29, 0};
`ifdef G15_MD_NORMALIZE_EN
        vecs[3] = '{3, 57, 5, 4, 23, 4, 232, 116, 54};
        vecs[6] = '{3, 5, 14, 1, 14, 1, 58, 29, 5};
`else
        vecs[3] = '{3, 57, 5, 4, 23, 57, 3306, 1653, 0};
        vecs[6] = '{3, 5, 14, 1, 14, 5, 290, 145, 0};
`endif
        vecs[4] = '{3, 2, 0, 0, 28, 2, 116, 58, 0};
        vecs[5] = '{0, 127, 20, 0, 8, 127, 7366, 3683, 0};
        vecs[7] = '{1, 4, 1, 0, 27, 4, 232, 116, 0};

        rst       = 1'b1;
        MD_GO     = 1'b0;
        MD_OP     = 2'd0;
        STEPS     = '0;
        ID_MSB    = 1'b0;
        prev_done = 1'b0;
        held_cnt  = 0;
        clear_counts();
        repeat (3) clk();
        chk("rst_outputs", int'({DS, CE, TE, BUSY, DONE, OP_MUL, OP_DIV}), 0);
        chk("rst_cnt", int'(CNT), 0);
        rst = 1'b0;

        // Reset in the middle of a MUL run: no DONE, everything cleared.
        wait_ph(3);
        MD_OP = 2'd0;
        STEPS = W'(5);
        MD_GO = 1'b1;
        clk();
        MD_GO = 1'b0;
        n = 0;
        while (te_cnt < 2 && n < 400) begin
            clk();
            n++;
        end
        chk("midrun_te_seen", te_cnt, 2);
        chk("midrun_active", int'(DS), 1);
        rst = 1'b1;
        clk();
        chk("midrun_rst_outputs", int'({DS, CE, TE, BUSY, DONE, OP_MUL, OP_DIV}), 0);
        chk("midrun_rst_cnt", int'(CNT), 0);
        rst = 1'b0;
        clear_counts();
        repeat (60) clk();
        chk("post_rst_idle", int'(BUSY), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // MD_GO during a DIV run is ignored and not queued.
        wait_ph(5);
        MD_OP = 2'd1;
        STEPS = W'(2);
        MD_GO = 1'b1;
        sb.push_back('{1, 2, 5, 0, 23, 2, 116, 58, 0});
        clk();
        MD_GO = 1'b0;
        repeat (40) clk();
        chk("div_running", int'(DS), 1);
        MD_OP = 2'd0;
        STEPS = W'(9);
        MD_GO = 1'b1;
        clk();
        MD_GO = 1'b0;
        MD_OP = 2'd1;
        chk("div_latched", int'(OP_DIV), 1);
        chk("mul_not_latched", int'(OP_MUL), 0);
        chk("cnt_not_reloaded", int'(CNT), 2);
        drain(300);
        busy_seen = 1'b0;
        repeat (60) begin
            clk();
            if (BUSY) busy_seen = 1'b1;
        end
        chk("go_not_queued", int'(busy_seen), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
